// File: rtl/layer6_pixel_quad_buffer_pkg.sv
// Shared CNN constants and types for the layer6 input stage: lane geometry,
// quad-bank selector encoding and the frame buffer state enum.
package layer6_pixel_quad_buffer_pkg;

    localparam int L6_IN_DIM   = 16;
    localparam int L6_POOL_DIM = L6_IN_DIM / 2;
    localparam int L6_LANES    = 8;
    localparam int L6_LANE_W   = 16;

    typedef logic [1:0] bank_sel_t;

    // Bank index is {row parity, col parity}.
    localparam bank_sel_t BANK_EE = 2'b00;
    localparam bank_sel_t BANK_EO = 2'b01;
    localparam bank_sel_t BANK_OE = 2'b10;
    localparam bank_sel_t BANK_OO = 2'b11;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } buf_state_t;

endpackage

// File: rtl/layer6_quad_bank.sv
// Single-port-write / single-port-read RAM with a registered read.
// A same-cycle read and write to one address returns the old word.
module layer6_quad_bank #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/layer6_pixel_quad_buffer.sv
// Frame buffer between layer5 and the layer6 2x2 pooling stage; stores pixels
// into four parity banks. Optional macro LAYER6_INPUT_RELU_EN zeroes negative lanes on store.
module layer6_pixel_quad_buffer
    import layer6_pixel_quad_buffer_pkg::*;
#(
    parameter int IN_DIM = L6_IN_DIM,
    parameter int LANES  = L6_LANES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          save_enable,
    input  logic [15:0]                   save_row,
    input  logic [15:0]                   save_col,
    input  logic [L6_LANE_W*LANES-1:0]    save_data,
    input  logic                          read_pixel_signal,
    input  logic [15:0]                   read_row_addr,
    input  logic [15:0]                   read_col_addr,
    input  logic                          layer6_calculation_done,
    output logic                          pixel_store_done,
    output logic [L6_LANE_W*LANES-1:0]    input_data_even_even,
    output logic [L6_LANE_W*LANES-1:0]    input_data_even_odd,
    output logic [L6_LANE_W*LANES-1:0]    input_data_odd_even,
    output logic [L6_LANE_W*LANES-1:0]    input_data_odd_odd,
    output logic                          wr_overflow
);

    localparam int W     = L6_LANE_W * LANES;
    localparam int HALF  = IN_DIM / 2;
    localparam int DEPTH = HALF * HALF;
    localparam int AW    = $clog2(DEPTH);
    localparam int TOTAL = IN_DIM * IN_DIM;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [15:0] DIM16  = 16'(IN_DIM);
    localparam logic [15:0] HALF16 = 16'(HALF);

    buf_state_t    state, next_state;
    logic [CW-1:0] count, next_count;
    logic          overflow_set;
    logic          wr_accept;
    logic          zero_out;

    logic          wr_in_range, rd_in_range;
    bank_sel_t     wr_sel;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [W-1:0]  store_data;
    logic [W-1:0]  bank_q [4];

    assign wr_in_range = (save_row < DIM16) && (save_col < DIM16);
    assign rd_in_range = (read_row_addr < HALF16) && (read_col_addr < HALF16);
    assign wr_sel      = {save_row[0], save_col[0]};

    // Coordinates are range-checked first, so only the low bits reach the address math.
    assign wr_addr = AW'(save_row[6:1]) * AW'(HALF) + AW'(save_col[6:1]);
    assign rd_addr = AW'(read_row_addr[5:0]) * AW'(HALF) + AW'(read_col_addr[5:0]);

    always_comb begin
        store_data = save_data;
`ifdef LAYER6_INPUT_RELU_EN
        for (int l = 0; l < LANES; l++) begin
            if (save_data[l*L6_LANE_W + L6_LANE_W - 1]) begin
                store_data[l*L6_LANE_W +: L6_LANE_W] = '0;
            end
        end
`endif
    end

    always_comb begin
        next_state   = state;
        next_count   = count;
        overflow_set = 1'b0;
        wr_accept    = 1'b0;
        case (state)
            FILL: begin
                if (save_enable && wr_in_range) begin
                    wr_accept  = 1'b1;
                    next_count = count + CW'(1);
                    if (count == CW'(TOTAL - 1)) begin
                        next_state = FULL;
                    end
                end
            end
            FULL: begin
                // A write racing the release pulse is still dropped and flagged.
                if (save_enable) begin
                    overflow_set = 1'b1;
                end
                if (layer6_calculation_done) begin
                    next_state = FILL;
                    next_count = '0;
                end
            end
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FILL;
            count       <= '0;
            wr_overflow <= 1'b0;
            zero_out    <= 1'b1;
        end else begin
            state <= next_state;
            count <= next_count;
            if (overflow_set) begin
                wr_overflow <= 1'b1;
            end
            if (read_pixel_signal) begin
                zero_out <= !rd_in_range;
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        layer6_quad_bank #(
            .DEPTH (DEPTH),
            .WIDTH (W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_accept && (wr_sel == bank_sel_t'(b))),
            .wr_addr (wr_addr),
            .wr_data (store_data),
            .rd_en   (read_pixel_signal && rd_in_range),
            .rd_addr (rd_addr),
            .rd_data (bank_q[b])
        );
    end

    assign pixel_store_done     = (state == FULL);
    assign input_data_even_even = zero_out ? '0 : bank_q[BANK_EE];
    assign input_data_even_odd  = zero_out ? '0 : bank_q[BANK_EO];
    assign input_data_odd_even  = zero_out ? '0 : bank_q[BANK_OE];
    assign input_data_odd_odd   = zero_out ? '0 : bank_q[BANK_OO];

endmodule

// File: tb/tb_layer6_pixel_quad_buffer.sv
// Directed bench for layer6_pixel_quad_buffer (IN_DIM=16, LANES=8); honours LAYER6_INPUT_RELU_EN.
module tb_layer6_pixel_quad_buffer;

    logic         clk;
    logic         rst;
    logic         save_enable;
    logic [15:0]  save_row, save_col;
    logic [127:0] save_data;
    logic         read_pixel_signal;
    logic [15:0]  read_row_addr, read_col_addr;
    logic         layer6_calculation_done;
    logic         pixel_store_done;
    logic [127:0] input_data_even_even, input_data_even_odd;
    logic [127:0] input_data_odd_even, input_data_odd_odd;
    logic         wr_overflow;

    int checks   = 0;
    int failures = 0;

`ifdef LAYER6_INPUT_RELU_EN
    localparam logic [15:0] RELU_EXP = 16'h0000;
`else
    localparam logic [15:0] RELU_EXP = 16'h8001;
`endif

    typedef struct {
        logic [15:0] r;
        logic [15:0] c;
        logic [15:0] ee;
        logic [15:0] eo;
        logic [15:0] oe;
        logic [15:0] oo;
    } rd_vec_t;

    rd_vec_t vecs [10];

    layer6_pixel_quad_buffer dut (
        .clk                     (clk),
        .rst                     (rst),
        .save_enable             (save_enable),
        .save_row                (save_row),
        .save_col                (save_col),
        .save_data               (save_data),
        .read_pixel_signal       (read_pixel_signal),
        .read_row_addr           (read_row_addr),
        .read_col_addr           (read_col_addr),
        .layer6_calculation_done (layer6_calculation_done),
        .pixel_store_done        (pixel_store_done),
        .input_data_even_even    (input_data_even_even),
        .input_data_even_odd     (input_data_even_odd),
        .input_data_odd_even     (input_data_odd_even),
        .input_data_odd_odd      (input_data_odd_odd),
        .wr_overflow             (wr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    function automatic logic [127:0] pix(input int r, input int c, input logic [15:0] base);
        logic [15:0] v;
        v = base + 16'(r * 16 + c);
        return {8{v}};
    endfunction

    // Drives one cycle of inputs at a falling edge and returns at the next
    // falling edge, so outputs seen afterwards reflect the rising edge between.
    task automatic applyStimulus(input logic we, input logic [15:0] wr, input logic [15:0] wc,
                                 input logic [127:0] wd, input logic re, input logic [15:0] rr,
                                 input logic [15:0] rc, input logic dn);
        save_enable             = we;
        save_row                = wr;
        save_col                = wc;
        save_data               = wd;
        read_pixel_signal       = re;
        read_row_addr           = rr;
        read_col_addr           = rc;
        layer6_calculation_done = dn;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkRead(input int k);
        applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b1, vecs[k].r, vecs[k].c, 1'b0);
        checkOutput($sformatf("read%0d_ee", k), input_data_even_even, rep(vecs[k].ee));
        checkOutput($sformatf("read%0d_eo", k), input_data_even_odd,  rep(vecs[k].eo));
        checkOutput($sformatf("read%0d_oe", k), input_data_odd_even,  rep(vecs[k].oe));
        checkOutput($sformatf("read%0d_oo", k), input_data_odd_odd,   rep(vecs[k].oo));
    endtask

    initial begin
        // Frame 1 holds {8{row*16+col}}
        vecs[0] = '{16'd3, 16'd5, 16'h006A, 16'h006B, 16'h007A, 16'h007B};
        vecs[1] = '{16'd0, 16'd0, 16'h0000, 16'h0001, 16'h0010, 16'h0011};
        vecs[2] = '{16'd7, 16'd7, 16'h00EE, 16'h00EF, 16'h00FE, 16'h00FF};
        vecs[3] = '{16'd2, 16'd6, 16'h004C, 16'h004D, 16'h005C, 16'h005D};
        vecs[4] = '{16'd8, 16'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{16'd0, 16'd8, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        // Frame 2 holds 0x1000+row*16+col, (0,0) rewritten with 8001, (15,15) left from frame 1
        vecs[6] = '{16'd0, 16'd0, RELU_EXP, 16'h1001, 16'h1010, 16'h1011};
        vecs[7] = '{16'd7, 16'd7, 16'h10EE, 16'h10EF, 16'h10FE, 16'h00FF};
        vecs[8] = '{16'd3, 16'd5, 16'h106A, 16'h106B, 16'h107A, 16'h107B};
        vecs[9] = '{16'd15, 16'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        rst = 1'b0;
        @(negedge clk);
        idle();
        idle();
        rst = 1'b1;
        checkOutput("reset_done", {127'd0, pixel_store_done}, 128'd0);
        checkOutput("reset_ovf",  {127'd0, wr_overflow}, 128'd0);
        checkOutput("reset_ee",   input_data_even_even, '0);
        checkOutput("reset_oo",   input_data_odd_odd, '0);

        // Partial frame abandoned by reset
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 16'(i / 16), 16'(i % 16), pix(i / 16, i % 16, 16'h0), 1'b0, 16'd0, 16'd0, 1'b0);
        end
        checkOutput("partial_done", {127'd0, pixel_store_done}, 128'd0);
        applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b1, 16'd0, 16'd0, 1'b0);
        checkOutput("partial_read_eo", input_data_even_odd, rep(16'h0001));
        rst = 1'b0;
        idle();
        rst = 1'b1;
        checkOutput("midreset_done", {127'd0, pixel_store_done}, 128'd0);
        checkOutput("midreset_eo",   input_data_even_odd, '0);

        // Frame 1: 256 writes with two out-of-range writes mixed in
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'(i / 16), 16'(i % 16), pix(i / 16, i % 16, 16'h0), 1'b0, 16'd0, 16'd0, 1'b0);
            if (i == 50) begin
                applyStimulus(1'b1, 16'd16, 16'd0, rep(16'hDEAD), 1'b0, 16'd0, 16'd0, 1'b0);
                applyStimulus(1'b1, 16'd0, 16'd16, rep(16'hBEEF), 1'b0, 16'd0, 16'd0, 1'b0);
                checkOutput("oor_write_ovf", {127'd0, wr_overflow}, 128'd0);
            end
            if (i == 254) begin
                checkOutput("f1_done_at_255", {127'd0, pixel_store_done}, 128'd0);
            end
        end
        checkOutput("f1_done_at_256", {127'd0, pixel_store_done}, 128'd1);

        for (int k = 0; k < 6; k++) begin
            checkRead(k);
        end

        // Outputs hold while no read is issued
        checkRead(0);
        idle();
        idle();
        idle();
        checkOutput("hold_oo", input_data_odd_odd, rep(16'h007B));

        // Write while FULL is dropped, then release with a racing write
        applyStimulus(1'b1, 16'd15, 16'd15, rep(16'hAAAA), 1'b0, 16'd0, 16'd0, 1'b0);
        checkOutput("full_write_ovf",  {127'd0, wr_overflow}, 128'd1);
        checkOutput("full_write_done", {127'd0, pixel_store_done}, 128'd1);
        applyStimulus(1'b1, 16'd15, 16'd15, rep(16'hBBBB), 1'b0, 16'd0, 16'd0, 1'b1);
        checkOutput("release_done", {127'd0, pixel_store_done}, 128'd0);
        checkOutput("release_ovf",  {127'd0, wr_overflow}, 128'd1);

        // Frame 2: 255 writes, release pulse ignored in FILL, collision read at (6,10)
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b1, 16'(i / 16), 16'(i % 16), pix(i / 16, i % 16, 16'h1000),
                          (i == 106), 16'd3, 16'd5, (i == 50));
            if (i == 50) begin
                checkOutput("fill_done_ignored", {127'd0, pixel_store_done}, 128'd0);
            end
            if (i == 106) begin
                checkOutput("collision_old_ee", input_data_even_even, rep(16'h006A));
            end
        end
        checkOutput("f2_done_at_255", {127'd0, pixel_store_done}, 128'd0);
        applyStimulus(1'b1, 16'd0, 16'd0, rep(16'h8001), 1'b0, 16'd0, 16'd0, 1'b0);
        checkOutput("f2_done_at_256", {127'd0, pixel_store_done}, 128'd1);
        checkOutput("f2_ovf_sticky",  {127'd0, wr_overflow}, 128'd1);

        for (int k = 6; k < 10; k++) begin
            checkRead(k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer6_pixel_quad_buffer.md
LAYER6_PIXEL_QUAD_BUFFER -- requirements
Module: layer6_pixel_quad_buffer

Interface
REQ-001 Parameter IN_DIM, default 16, input feature-map height and width in pixels; even, 4..64.
REQ-002 Parameter LANES, default 8, number of 16-bit channel lanes per pixel word (word width 16*LANES = 128).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 save_enable  input  1  write strobe from the layer5 stage.
REQ-006 save_row, save_col  input  16 each  pixel write coordinates.
REQ-007 save_data  input  128  pixel word to store.
REQ-008 read_pixel_signal  input  1  read strobe from the layer6 pooling stage.
REQ-009 read_row_addr, read_col_addr  input  16 each  pooled-grid coordinates of the 2x2 window to read.
REQ-010 layer6_calculation_done  input  1  consumer pulse; releases the buffer for the next frame.
REQ-011 pixel_store_done  output  1  level; a complete frame is stored and readable.
REQ-012 input_data_even_even, input_data_even_odd, input_data_odd_even, input_data_odd_odd  output  128 each  window pixels (row parity, col parity).
REQ-013 wr_overflow  output  1  sticky; a write was dropped.

Function
REQ-014 Storage SHALL be four banks selected by {row[0], col[0]}, each (IN_DIM/2)^2 words, indexed by (row>>1)*(IN_DIM/2)+(col>>1).
REQ-015 State machine SHALL have states FILL and FULL; reset enters FILL.
REQ-016 In FILL, a write with save_enable=1 and both coordinates < IN_DIM SHALL store save_data and increment the write counter.
REQ-017 Writes with either coordinate >= IN_DIM SHALL be ignored, leave the counter unchanged, and leave wr_overflow unchanged.
REQ-018 When an accepted write brings the counter to IN_DIM*IN_DIM, the next cycle SHALL be FULL with pixel_store_done=1.
REQ-019 Rewriting an already-written coordinate SHALL overwrite the data and still count.
REQ-020 In FULL, every save_enable=1 SHALL be dropped and set wr_overflow=1.
REQ-021 In FULL, layer6_calculation_done=1 SHALL return the block to FILL the next cycle, clear the counter and drop pixel_store_done; bank contents are retained.
REQ-022 If a write and layer6_calculation_done occur in the same FULL cycle, the done SHALL take effect, the write SHALL be dropped, and wr_overflow SHALL be set.
REQ-023 layer6_calculation_done in FILL SHALL be ignored.
REQ-024 A read SHALL return, one cycle after read_pixel_signal=1, the four pixels (2r+a, 2c+b) on the matching outputs.
REQ-025 Outputs SHALL hold their value while read_pixel_signal=0.
REQ-026 A read with read_row_addr or read_col_addr >= IN_DIM/2 SHALL return all-zero outputs.
REQ-027 Reads SHALL be honoured in both states; the consumer only issues reads while pixel_store_done=1.
REQ-028 A same-cycle read and write to the same location SHALL return the old data.

Reset
REQ-029 While rst=0 at a clock edge: state=FILL, counter=0, pixel_store_done=0, wr_overflow=0, all four data outputs=0.
REQ-030 Bank contents SHALL NOT be reset.
REQ-031 Reset mid-frame SHALL abandon the frame; the next frame restarts counting from 0.

Configuration
REQ-032 Macro LAYER6_INPUT_RELU_EN: when defined, each 16-bit lane of save_data with bit 15 set SHALL be stored as 0. When undefined, data SHALL be stored unmodified.

Structure
REQ-033 LANES, the lane width (16), the 2-bit bank-select typedef and the FILL/FULL state enum SHALL live in the shared CNN package beside the existing LAYER6 constants.
REQ-034 One sub-module, layer6_quad_bank (single synchronous-read RAM: one write port, one read port), SHALL be instantiated four times.

Verification
REQ-035 Reset, then 256 writes with data={8{row*16+col}} (IN_DIM=16) -> pixel_store_done=1 on the cycle after the 256th write.
REQ-036 Read (r=3, c=5) -> next cycle the outputs carry pixels (6,10), (6,11), (7,10), (7,11), in that order: even_even, even_odd, odd_even, odd_odd.
REQ-037 Write while FULL, then pulse layer6_calculation_done -> wr_overflow=1, pixel_store_done=0 next cycle; a second frame of 256 writes sets pixel_store_done=1 again.
REQ-038 Write to (16,0) and read (8,0) -> counter unchanged and all outputs 0.
REQ-039 With LAYER6_INPUT_RELU_EN defined, write lane value 16'h8001 -> read back as 16'h0000; without the macro -> 16'h8001.
REQ-040 Apply rst=0 after 100 writes -> pixel_store_done=0; 256 further writes are required to set it.
